painel_tick_receptor: RTL and testbench

- Receiving end of the ripple JK clock-divider chain: takes the two divided-clock taps (fast tap clk/32, slow tap clk/2^23) and turns them into single-cycle strobes in the main clk domain.
- Drives the panel's BCD mm:ss timer from the slow strobe.
- Monitors the slow tap and flags a dead or stuck divider.
- Sits between the divider and the display/segment decoders. Everything downstream runs on clk plus these enables, never on the divided clocks.

---
 rtl/painel_tick_receptor.sv | 193 +++++++++++++++++++
 tb/tb_painel_tick_receptor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/painel_tick_receptor.sv
`default_nettype none
// ============================================================================
//  Module   : painel_tick_receptor
//  Purpose  : Receiving end of the ripple JK divider chain. Brings the fast
//             (clk/32) and slow (clk/2^23) divided taps into the clk domain
//             as one-cycle strobes, runs the panel BCD mm:ss timer from the
//             slow strobe and flags a dead or stuck divider.
//  Ports    : clk, reset         - system clock, async active-high reset
//             div_rapido/lento   - divided taps, asynchronous to clk
//             iniciar/parar/zerar- one-cycle timer control pulses
//             tick_rapido/lento  - one-cycle strobes per tap rising edge
//             seg_uni..min_dez   - BCD mm:ss digits
//             contando, fim      - timer running / held at 99:59
//             sem_sinal          - divider watchdog alarm
//  Revision : 1.0 - initial release
// ============================================================================
module painel_tick_receptor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CICLOS = 16777216,
  parameter int unsigned CONT_W         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div_rapido,
  input  logic       div_lento,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       zerar,
  output logic       tick_rapido,
  output logic       tick_lento,
  output logic [3:0] seg_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] min_uni,
  output logic [3:0] min_dez,
  output logic       contando,
  output logic       fim,
  output logic       sem_sinal
);

  localparam logic [CONT_W-1:0] c_timeout = CONT_W'(TIMEOUT_CICLOS);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    ESTOURO  = 2'd2
  } estado_t;

  // --------------------------------------------------------------------------
  // Synchronizers and rising-edge strobes
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_r_q, sync_l_q;
  logic                   hist_r_q, hist_l_q;
  logic                   tick_r_q, tick_l_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r_q <= '0;
      sync_l_q <= '0;
      hist_r_q <= 1'b0;
      hist_l_q <= 1'b0;
      tick_r_q <= 1'b0;
      tick_l_q <= 1'b0;
    end else begin
      sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], div_rapido};
      sync_l_q <= {sync_l_q[SYNC_STAGES-2:0], div_lento};
      hist_r_q <= sync_r_q[SYNC_STAGES-1];
      hist_l_q <= sync_l_q[SYNC_STAGES-1];
      tick_r_q <= sync_r_q[SYNC_STAGES-1] & ~hist_r_q;
      tick_l_q <= sync_l_q[SYNC_STAGES-1] & ~hist_l_q;
    end
  end

  // --------------------------------------------------------------------------
  // Timer FSM and BCD digits
  // --------------------------------------------------------------------------
  estado_t    estado_q, estado_d;
  logic [3:0] su_q, sd_q, mu_q, md_q;
  logic [3:0] su_d, sd_d, mu_d, md_d;
  logic       contando_q, fim_q;

  always_comb begin
    estado_d = estado_q;
    su_d     = su_q;
    sd_d     = sd_q;
    mu_d     = mu_q;
    md_d     = md_q;
    if (zerar) begin
      su_d     = 4'd0;
      sd_d     = 4'd0;
      mu_d     = 4'd0;
      md_d     = 4'd0;
      estado_d = PARADO;
    end else begin
      case (estado_q)
        PARADO: begin
          // A tick coinciding with the start pulse is deliberately dropped.
          if (iniciar) estado_d = CONTANDO;
        end
        CONTANDO: begin
          if (parar) begin
            estado_d = PARADO;
          end else if (tick_l_q) begin
            // Ripple carry decided on current digits, so no digit ever
            // passes through an out-of-range value.
            if (su_q != 4'd9) begin
              su_d = su_q + 4'd1;
            end else begin
              su_d = 4'd0;
              if (sd_q != 4'd5) begin
                sd_d = sd_q + 4'd1;
              end else begin
                sd_d = 4'd0;
                if (mu_q != 4'd9) begin
                  mu_d = mu_q + 4'd1;
                end else begin
                  mu_d = 4'd0;
                  md_d = (md_q == 4'd9) ? 4'd0 : md_q + 4'd1;
                end
              end
            end
            if (md_q == 4'd9 && mu_q == 4'd9 && sd_q == 4'd5 && su_q == 4'd8)
              estado_d = ESTOURO;
          end
        end
        ESTOURO: begin
          // Held at 99:59 until zerar or reset.
        end
        default: estado_d = PARADO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= PARADO;
      su_q       <= 4'd0;
      sd_q       <= 4'd0;
      mu_q       <= 4'd0;
      md_q       <= 4'd0;
      contando_q <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      su_q       <= su_d;
      sd_q       <= sd_d;
      mu_q       <= mu_d;
      md_q       <= md_d;
      // Decoded from the next state so the flags line up with estado_q.
      contando_q <= (estado_d == CONTANDO);
      fim_q      <= (estado_d == ESTOURO);
    end
  end

  // --------------------------------------------------------------------------
  // Divider watchdog
  // --------------------------------------------------------------------------
  logic [CONT_W-1:0] cnt_q, cnt_d;
  logic              sem_q, sem_d;

  always_comb begin
    cnt_d = cnt_q;
    sem_d = sem_q;
    if (tick_l_q) begin
      cnt_d = '0;
      sem_d = 1'b0;
    end else begin
      if (cnt_q != c_timeout) cnt_d = cnt_q + CONT_W'(1);
      if (cnt_d == c_timeout) sem_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sem_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sem_q <= sem_d;
    end
  end

  assign tick_rapido = tick_r_q;
  assign tick_lento  = tick_l_q;
  assign seg_uni     = su_q;
  assign seg_dez     = sd_q;
  assign min_uni     = mu_q;
  assign min_dez     = md_q;
  assign contando    = contando_q;
  assign fim         = fim_q;
  assign sem_sinal   = sem_q;

endmodule
`default_nettype wire

// File: tb/tb_painel_tick_receptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_painel_tick_receptor
//  Purpose  : Self-checking bench for painel_tick_receptor. Timer results are
//             predicted per slow tick into a queue; a monitor pops one entry
//             per observed tick_lento and compares the settled outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_painel_tick_receptor;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       div_rapido = 1'b0, div_lento = 1'b0;
  logic       iniciar = 1'b0, parar = 1'b0, zerar = 1'b0;
  logic       tick_rapido, tick_lento, contando, fim, sem_sinal;
  logic [3:0] seg_uni, seg_dez, min_uni, min_dez;

  painel_tick_receptor #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CICLOS (TMO),
    .CONT_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .div_rapido (div_rapido),
    .div_lento  (div_lento),
    .iniciar    (iniciar),
    .parar      (parar),
    .zerar      (zerar),
    .tick_rapido(tick_rapido),
    .tick_lento (tick_lento),
    .seg_uni    (seg_uni),
    .seg_dez    (seg_dez),
    .min_uni    (min_uni),
    .min_dez    (min_dez),
    .contando   (contando),
    .fim        (fim),
    .sem_sinal  (sem_sinal)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected {min_dez,min_uni,seg_dez,seg_uni,contando,fim,sem_sinal}
  logic [18:0] exp_q[$];
  bit          mon_pend = 1'b0;

  // Bench model of the timer: elapsed seconds plus state (0 P, 1 C, 2 E)
  int m_sec = 0;
  int m_st  = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic model_step(input logic z, input logic p, input logic i);
    int mm, ss;
    if (z) begin
      m_sec = 0; m_st = 0;
    end else if (m_st == 0) begin
      if (i) m_st = 1;
    end else if (m_st == 1) begin
      if (p) m_st = 0;
      else begin
        m_sec++;
        if (m_sec == 5999) m_st = 2;
      end
    end
    mm = m_sec / 60;
    ss = m_sec % 60;
    exp_q.push_back({4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                     (m_st == 1), (m_st == 2), 1'b0});
  endtask

  // One rising edge on div_lento; the control pulses land in the cycle
  // where tick_lento is high.
  task automatic tick_with(input logic z, input logic p, input logic i);
    @(negedge clk); div_lento = 1'b1;
    repeat (3) @(negedge clk);
    zerar = z; parar = p; iniciar = i;
    model_step(z, p, i);
    @(negedge clk);
    zerar = 1'b0; parar = 1'b0; iniciar = 1'b0; div_lento = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick_with(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are compared one cycle after each tick_lento strobe.
  initial begin
    logic [18:0] act, req;
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        act = {min_dez, min_uni, seg_dez, seg_uni, contando, fim, sem_sinal};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL timer_out: unexpected tick, actual %h required none", act);
        end else begin
          req = exp_q.pop_front();
          if (act !== req) begin
            n_err++;
            $display("FAIL timer_out: actual %h required %h (mmss_c_f_s)", act, req);
          end
        end
      end
      mon_pend = (tick_lento === 1'b1);
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: actual stuck required finish");
    $fatal(1, "timeout");
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_digits"}, int'({min_dez, min_uni, seg_dez, seg_uni}), 0);
    chk({nm, "_contando"}, int'(contando), 0);
    chk({nm, "_fim"}, int'(fim), 0);
    chk({nm, "_sem"}, int'(sem_sinal), 0);
    chk({nm, "_ticks"}, int'({tick_rapido, tick_lento}), 0);
  endtask

  initial begin
    int hi, bad, j;
    bit exp_hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Fast tap: 32-cycle square wave
    hi = 0; bad = 0;
    for (int k = 0; k < 136; k++) begin
      @(negedge clk);
      exp_hi = (k >= 3) && (((k - 3) % 32) == 0);
      if (tick_rapido !== exp_hi) bad++;
      if (tick_rapido === 1'b1) hi++;
      div_rapido = ((k % 32) < 16);
    end
    div_rapido = 1'b0;
    chk("rapido_pattern_errs", bad, 0);
    chk("rapido_pulses", hi, 5);
    repeat (10) @(negedge clk);
    // Held high: exactly one strobe
    hi = 0;
    div_rapido = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (k == 100) div_rapido = 1'b0;
      if (tick_rapido === 1'b1) hi++;
    end
    chk("rapido_held_pulses", hi, 1);

    // Start (same-cycle tick ignored), 60 s, stop on the 61st tick
    tick_with(1'b0, 1'b0, 1'b1);
    ticks(60);
    tick_with(1'b0, 1'b1, 1'b0);

    // Resume to 05:07 then zerar+parar+iniciar together
    tick_with(1'b0, 1'b0, 1'b1);
    ticks(247);
    tick_with(1'b1, 1'b1, 1'b1);

    // Overflow: 99:57 -> 99:58 -> 99:59 (fim) -> hold
    tick_with(1'b0, 1'b0, 1'b1);
    ticks(5997);
    ticks(4);
    tick_with(1'b0, 1'b0, 1'b1);
    tick_with(1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count at 12:34 with div_lento active
    tick_with(1'b0, 1'b0, 1'b1);
    ticks(754);
    chk("pre_reset_digits", int'({min_dez, min_uni, seg_dez, seg_uni}), 16'h1234);
    @(negedge clk);
    div_lento = 1'b1;
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    m_sec = 0; m_st = 0;
    @(negedge clk); div_lento = 1'b0;
    @(negedge clk); div_lento = 1'b1;
    @(negedge clk); div_lento = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tick_lento === 1'b1) hi++;
    end
    chk("post_reset_no_tick", hi, 0);
    tick_with(1'b0, 1'b0, 1'b0);

    // Watchdog: latency from the edge that ended the last tick
    tick_with(1'b0, 1'b0, 1'b0);
    j = 2;
    while (sem_sinal !== 1'b1 && j < 200) begin
      @(negedge clk);
      j++;
    end
    chk("wdog_latency", j, TMO);
    repeat (20) @(negedge clk);
    chk("wdog_held", int'(sem_sinal), 1);
    tick_with(1'b0, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
